spi_controller: RTL and testbench

//  - SPI mode-0 initiator. Sends 16-bit write frames to the on-chip SPI register peripheral.
//  - Drives sclk, ncs and copi. Intended for test harnesses and for an on-chip sequencer that

---
 rtl/spi_controller_if.sv | 12 +
 rtl/spi_controller.sv | 156 +++++++++++++++
 tb/tb_spi_controller.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_controller_if.sv
// Host-side request/status bundle for spi_controller: start/addr/data in, busy/done/err out.
interface spi_controller_if;
  logic       start;
  logic [6:0] addr;
  logic [7:0] data;
  logic       busy;
  logic       done;
  logic       err;

  modport master (output start, addr, data, input busy, done, err);
  modport slave  (input start, addr, data, output busy, done, err);
endinterface

// File: rtl/spi_controller.sv
// SPI mode-0 initiator sending 16-bit write frames {1'b1, addr[6:0], data[7:0]} MSB first.
// Define SPI_CTRL_ADDR_CHECK_EN to reject addresses above MAX_ADDR with an err pulse.
module spi_controller #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_GAP   = 4,
  parameter int unsigned MAX_ADDR = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_controller_if.slave bus,
  output logic            sclk,
  output logic            ncs,
  output logic            copi
);

  localparam int unsigned PH_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int unsigned CW     = $clog2(PH_MAX);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(CS_GAP - 1);

  // Shorter phases would outrun the peripheral's 3-flop input synchroniser.
  if (CLK_DIV < 4 || CS_GAP < 4 || MAX_ADDR > 127) begin : g_param_check
    $error("spi_controller: CLK_DIV/CS_GAP must be >= 4 and MAX_ADDR <= 127");
  end

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;

  state_t        state;
  logic [CW-1:0] ph_cnt;
  logic [3:0]    bit_cnt;
  logic [15:0]   shreg;
  logic          busy_q;
  logic          done_q;

`ifdef SPI_CTRL_ADDR_CHECK_EN
  localparam logic [6:0] ADDR_LIMIT = 7'(MAX_ADDR);
  logic err_q;
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.busy = busy_q;
  assign bus.done = done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ph_cnt  <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      sclk    <= 1'b0;
      ncs     <= 1'b1;
      copi    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SPI_CTRL_ADDR_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef SPI_CTRL_ADDR_CHECK_EN
      err_q  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          ph_cnt  <= '0;
          bit_cnt <= '0;
          if (bus.start && !busy_q) begin
`ifdef SPI_CTRL_ADDR_CHECK_EN
            if (bus.addr > ADDR_LIMIT) begin
              err_q <= 1'b1;
            end else begin
              shreg  <= {1'b1, bus.addr, bus.data};
              ncs    <= 1'b0;
              copi   <= 1'b1;
              busy_q <= 1'b1;
              state  <= SETUP;
            end
`else
            // The write flag is always the first bit on the wire.
            shreg  <= {1'b1, bus.addr, bus.data};
            ncs    <= 1'b0;
            copi   <= 1'b1;
            busy_q <= 1'b1;
            state  <= SETUP;
`endif
          end
        end

        SETUP: begin
          if (ph_cnt == DIV_LAST) begin
            ph_cnt <= '0;
            sclk   <= 1'b1;
            state  <= HIGH;
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end

        HIGH: begin
          if (ph_cnt == DIV_LAST) begin
            ph_cnt  <= '0;
            sclk    <= 1'b0;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 4'd15) begin
              state <= HOLD;
            end else begin
              // Next bit goes out on the falling edge, a full phase before the next rise.
              shreg <= {shreg[14:0], 1'b0};
              copi  <= shreg[14];
              state <= LOW;
            end
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end

        LOW: begin
          if (ph_cnt == DIV_LAST) begin
            ph_cnt <= '0;
            sclk   <= 1'b1;
            state  <= HIGH;
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end

        HOLD: begin
          if (ph_cnt == DIV_LAST) begin
            ph_cnt <= '0;
            ncs    <= 1'b1;
            copi   <= 1'b0;
            state  <= GAP;
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end

        GAP: begin
          if (ph_cnt == GAP_LAST) begin
            ph_cnt <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= IDLE;
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench for spi_controller: stimulus queues expected frames, a monitor decodes the SPI pins.
module tb_spi_controller;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic sclk, ncs, copi;

  spi_controller_if bus ();

  spi_controller #(.CLK_DIV(4), .CS_GAP(4), .MAX_ADDR(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .sclk (sclk),
    .ncs  (ncs),
    .copi (copi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    int unsigned nbits;
  } frame_t;

  frame_t      exp_q[$];
  int unsigned err_expected = 0;
  int unsigned vectors      = 0;
  int unsigned miscompares  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: rebuild each frame from copi at sclk rises, score it when ncs releases.
  logic        sclk_p = 1'b0;
  logic        ncs_p  = 1'b1;
  logic [15:0] cap    = '0;
  int unsigned nbits  = 0;
  frame_t      mon_f;

  always @(negedge clk) begin
    if (ncs_p === 1'b1 && ncs === 1'b0) begin
      cap   = '0;
      nbits = 0;
    end
    if (sclk === 1'b1 && sclk_p === 1'b0) begin
      chk("rise_with_ncs_low", 32'(ncs), 32'd0);
      cap = {cap[14:0], copi};
      nbits++;
    end
    if (ncs === 1'b1 && ncs_p === 1'b0) begin
      chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_f = exp_q.pop_front();
        chk("frame_word", 32'(cap), 32'(mon_f.word));
        chk("frame_bits", 32'(nbits), 32'(mon_f.nbits));
      end
    end
    if (bus.err === 1'b1) begin
      chk("err_expected", 32'(err_expected != 0), 32'd1);
      if (err_expected != 0) err_expected--;
    end
    sclk_p = sclk;
    ncs_p  = ncs;
  end

  task automatic issue(input logic [6:0] a, input logic [7:0] d,
                       input logic [15:0] w, input int unsigned nb);
    frame_t f;
    f.word  = w;
    f.nbits = nb;
    @(negedge clk);
    exp_q.push_back(f);
    bus.start = 1'b1;
    bus.addr  = a;
    bus.data  = d;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Counts negedges from the one just after the accept edge until done is seen.
  task automatic wait_done(output int unsigned cyc);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", 32'(bus.done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned cyc;
    int unsigned hi;
    int unsigned gap;
    int unsigned rises;
    logic        sp;
    logic        seen;

    bus.start = 1'b0;
    bus.addr  = '0;
    bus.data  = '0;

    // Reset
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_sclk", 32'(sclk), 32'd0);
    chk("reset_ncs",  32'(ncs),  32'd1);
    chk("reset_copi", 32'(copi), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_err",  32'(bus.err),  32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame, duty register
    issue(7'h04, 8'hA5, 16'h84A5, 16);
    chk("busy_after_accept", 32'(bus.busy), 32'd1);
    chk("ncs_after_accept", 32'(ncs), 32'd0);
    chk("copi_after_accept", 32'(copi), 32'd1);
    wait_done(cyc);
    chk("latency", 32'(cyc), 32'd136);
    chk("busy_at_done", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", 32'(bus.done), 32'd0);
    repeat (3) @(negedge clk);

    // Held start: two back-to-back frames
    @(negedge clk);
    exp_q.push_back('{word: 16'h80FF, nbits: 16});
    bus.start = 1'b1;
    bus.addr  = 7'h00;
    bus.data  = 8'hFF;
    @(negedge clk);
    exp_q.push_back('{word: 16'h810F, nbits: 16});
    bus.addr = 7'h01;
    bus.data = 8'h0F;
    hi  = 0;
    gap = 0;
    cyc = 0;
    while (gap == 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (ncs === 1'b1) begin
        hi++;
      end else begin
        if (hi != 0) begin
          gap       = hi;
          bus.start = 1'b0;
        end
        hi = 0;
      end
    end
    bus.start = 1'b0;
    chk("b2b_gap", 32'(gap), 32'd5);
    wait_done(cyc);
    chk("b2b_latency", 32'(cyc), 32'd136);
    repeat (3) @(negedge clk);
    chk("b2b_no_third", 32'(bus.busy), 32'd0);

    // start pulsed mid-frame is ignored
    issue(7'h04, 8'h33, 16'h8433, 16);
    repeat (9) @(negedge clk);
    bus.start = 1'b1;
    bus.addr  = 7'h02;
    bus.data  = 8'h77;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(cyc);
    chk("ignored_latency", 32'(cyc), 32'd126);
    repeat (3) @(negedge clk);
    chk("ignored_not_queued", 32'(bus.busy), 32'd0);

    // Reset after the 8th sclk rise
    issue(7'h01, 8'h55, 16'h0081, 8);
    rises = 0;
    sp    = sclk;
    seen  = 1'b0;
    cyc   = 0;
    while (rises < 8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (sclk === 1'b1 && sp === 1'b0) rises++;
      sp   = sclk;
      seen = seen | (bus.done === 1'b1);
    end
    chk("midframe_rises", 32'(rises), 32'd8);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_ncs",  32'(ncs),  32'd1);
    chk("midreset_sclk", 32'(sclk), 32'd0);
    chk("midreset_copi", 32'(copi), 32'd0);
    chk("midreset_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    repeat (150) begin
      @(negedge clk);
      seen = seen | (bus.done === 1'b1);
    end
    chk("midreset_no_done", 32'(seen), 32'd0);

    // Address above MAX_ADDR
`ifdef SPI_CTRL_ADDR_CHECK_EN
    @(negedge clk);
    err_expected++;
    bus.start = 1'b1;
    bus.addr  = 7'h05;
    bus.data  = 8'h3C;
    @(negedge clk);
    bus.start = 1'b0;
    chk("reject_err", 32'(bus.err), 32'd1);
    chk("reject_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("reject_err_one_cycle", 32'(bus.err), 32'd0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | (ncs !== 1'b1) | (sclk !== 1'b0) | (copi !== 1'b0)
                  | (bus.busy !== 1'b0) | (bus.done !== 1'b0);
    end
    chk("reject_quiet", 32'(seen), 32'd0);
`else
    issue(7'h05, 8'h3C, 16'h853C, 16);
    wait_done(cyc);
    chk("addr5_latency", 32'(cyc), 32'd136);
`endif

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("err_drained", 32'(err_expected), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
